// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: opcodes, state encoding and
// the select encodings that the datapath decodes.
package multicycle_controller_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_OP, CLS_OP_IMM, CLS_LUI, CLS_AUIPC,
    CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_MISC_MEM, CLS_SYSTEM, CLS_ILLEGAL
  } op_class_e;

  localparam logic [1:0] PCSRC_PLUS4 = 2'd0;
  localparam logic [1:0] PCSRC_ALU   = 2'd1;
  localparam logic [1:0] PCSRC_JALR  = 2'd2;

  localparam logic [1:0] ALUA_RS1  = 2'd0;
  localparam logic [1:0] ALUA_PC   = 2'd1;
  localparam logic [1:0] ALUA_ZERO = 2'd2;

  localparam logic [1:0] ALUB_RS2  = 2'd0;
  localparam logic [1:0] ALUB_IMM  = 2'd1;
  localparam logic [1:0] ALUB_FOUR = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_ECALL   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam logic [4:0] IMM_NONE = 5'b00000;
  localparam logic [4:0] IMM_I    = 5'b10000;
  localparam logic [4:0] IMM_S    = 5'b01000;
  localparam logic [4:0] IMM_B    = 5'b00100;
  localparam logic [4:0] IMM_U    = 5'b00010;
  localparam logic [4:0] IMM_J    = 5'b00001;

endpackage

// File: rtl/multicycle_controller_opcode_decode.sv
// Opcode classification: instruction class, legality and immediate format.
module opcode_decode
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       legal,
  output logic [4:0] imm_fmt
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OPC_LOAD:     op_class = CLS_LOAD;
      OPC_STORE:    op_class = CLS_STORE;
      OPC_OP:       op_class = CLS_OP;
      OPC_OP_IMM:   op_class = CLS_OP_IMM;
      OPC_LUI:      op_class = CLS_LUI;
      OPC_AUIPC:    op_class = CLS_AUIPC;
      OPC_JAL:      op_class = CLS_JAL;
      OPC_JALR:     op_class = CLS_JALR;
      OPC_BRANCH:   op_class = CLS_BRANCH;
      OPC_MISC_MEM: op_class = CLS_MISC_MEM;
      OPC_SYSTEM:   op_class = CLS_SYSTEM;
      default:      op_class = CLS_ILLEGAL;
    endcase
  end

  // SYSTEM is recognised but not executed, so it is not "legal" for EXEC.
  assign legal = (op_class != CLS_ILLEGAL) && (op_class != CLS_SYSTEM);

  always_comb begin
    imm_fmt = IMM_NONE;
    case (opcode[6:2])
      OPC_LOAD[6:2], OPC_OP_IMM[6:2], OPC_JALR[6:2],
      OPC_MISC_MEM[6:2], OPC_SYSTEM[6:2]: imm_fmt = IMM_I;
      OPC_STORE[6:2]:                     imm_fmt = IMM_S;
      OPC_BRANCH[6:2]:                    imm_fmt = IMM_B;
      OPC_LUI[6:2], OPC_AUIPC[6:2]:       imm_fmt = IMM_U;
      OPC_JAL[6:2]:                       imm_fmt = IMM_J;
      default:                            imm_fmt = IMM_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory wait timeout and an absorbing TRAP state.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Ins,
  input  logic        MemReady,
  input  logic        BranchTaken,
  output logic        MemReq,
  output logic        MemAddrSel,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [4:0]  ImmFmt,
  output logic        RegWrite,
  output logic [1:0]  ResultSel,
  output logic        InstRetired,
  output logic        Halt,
  output logic [1:0]  Cause
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic          retire;

  op_class_e op_class;
  logic      legal;
  logic [4:0] imm_fmt;
  logic      unused_ins_bits;

  logic       mem_req, mem_addr_sel, mem_write, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, result_sel;
  logic [1:0] cls_a, cls_b, cls_op;
  logic [4:0] imm_out;
  logic       wait_expired;

  opcode_decode u_opcode_decode (
    .opcode   (Ins[6:0]),
    .op_class (op_class),
    .legal    (legal),
    .imm_fmt  (imm_fmt)
  );

  assign unused_ins_bits = ^Ins[31:7];
  assign wait_expired    = (wait_q == CW'(MEM_TIMEOUT - 1));

  // The wait counter only advances in FETCH/MEM while memory is not ready,
  // so it is already zero whenever one of those states is entered.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (MemReady) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_DECODE: begin
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = (op_class == CLS_SYSTEM) ? CAUSE_ECALL : CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH, CLS_MISC_MEM: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (MemReady) begin
          if (op_class == CLS_STORE) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // ALU operand selection per class, held from EXEC through WB so the
  // ALU result stays valid for the address and writeback.
  always_comb begin
    cls_a  = ALUA_RS1;
    cls_b  = ALUB_IMM;
    cls_op = ALUOP_ADD;
    case (op_class)
      CLS_OP: begin
        cls_b  = ALUB_RS2;
        cls_op = ALUOP_FUNCT;
      end
      CLS_OP_IMM:         cls_op = ALUOP_FUNCT;
      CLS_LUI:            cls_a  = ALUA_ZERO;
      CLS_AUIPC, CLS_JAL: cls_a  = ALUA_PC;
      CLS_BRANCH: begin
        cls_b  = ALUB_RS2;
        cls_op = ALUOP_BRANCH;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PCSRC_PLUS4;
    alu_src_a    = ALUA_RS1;
    alu_src_b    = ALUB_RS2;
    alu_op       = ALUOP_ADD;
    imm_out      = IMM_NONE;
    reg_write    = 1'b0;
    result_sel   = RES_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = ALUA_PC;
        alu_src_b = ALUB_FOUR;
        ir_write  = MemReady;
        pc_write  = MemReady;
      end
      ST_DECODE: imm_out = imm_fmt;
      ST_EXEC: begin
        imm_out   = imm_fmt;
        alu_src_a = cls_a;
        alu_src_b = cls_b;
        alu_op    = cls_op;
        case (op_class)
          CLS_JAL: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_ALU;
          end
          CLS_JALR: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_JALR;
          end
          CLS_BRANCH: begin
            pc_write = BranchTaken;
            pc_src   = PCSRC_ALU;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        imm_out      = imm_fmt;
        alu_src_a    = cls_a;
        alu_src_b    = cls_b;
        alu_op       = cls_op;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_write    = (op_class == CLS_STORE);
      end
      ST_WB: begin
        imm_out   = imm_fmt;
        alu_src_a = cls_a;
        alu_src_b = cls_b;
        alu_op    = cls_op;
        reg_write = 1'b1;
        if (op_class == CLS_LOAD)
          result_sel = RES_MEM;
        else if (op_class == CLS_JAL || op_class == CLS_JALR)
          result_sel = RES_PC4;
      end
      default: ;
    endcase
  end

  assign MemReq      = mem_req & ~Rst;
  assign MemAddrSel  = mem_addr_sel;
  assign MemWrite    = mem_write & ~Rst;
  assign IRWrite     = ir_write & ~Rst;
  assign PCWrite     = pc_write & ~Rst;
  assign PCSrc       = pc_src;
  assign ALUSrcA     = alu_src_a;
  assign ALUSrcB     = alu_src_b;
  assign ALUOp       = alu_op;
  assign ImmFmt      = imm_out;
  assign RegWrite    = reg_write & ~Rst;
  assign ResultSel   = result_sel;
  assign InstRetired = retire & ~Rst;
  assign Halt        = (state_q == ST_TRAP);
  assign Cause       = cause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction
// sequences plus randomized instructions and memory latencies.
module tb_multicycle_controller;

  localparam int TIMEOUT = 4;

  logic        Clk, Rst, MemReady, BranchTaken;
  logic [31:0] Ins;
  logic        MemReq, MemAddrSel, MemWrite, IRWrite, PCWrite, RegWrite;
  logic        InstRetired, Halt;
  logic [1:0]  PCSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSel, Cause;
  logic [4:0]  ImmFmt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {K_LOAD, K_STORE, K_OP, K_OPIMM, K_LUI, K_AUIPC, K_JAL, K_JALR,
                K_BRANCH, K_FENCE, K_SYSTEM, K_ILLEGAL} kind_e;

  typedef struct {
    logic       mem_req, mem_addr_sel, mem_write, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] result_sel;
    logic       retired;
    logic [4:0] imm_fmt;
    logic       chk_status, halt;
    logic [1:0] cause;
    logic       chk_alu;
    logic [1:0] alu_a, alu_b, alu_op;
  } exp_t;

  multicycle_controller #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .Ins(Ins), .MemReady(MemReady), .BranchTaken(BranchTaken),
    .MemReq(MemReq), .MemAddrSel(MemAddrSel), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmFmt(ImmFmt), .RegWrite(RegWrite), .ResultSel(ResultSel),
    .InstRetired(InstRetired), .Halt(Halt), .Cause(Cause)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic kind_e kind_of(input logic [6:0] opc);
    case (opc)
      7'h03:   return K_LOAD;
      7'h23:   return K_STORE;
      7'h33:   return K_OP;
      7'h13:   return K_OPIMM;
      7'h37:   return K_LUI;
      7'h17:   return K_AUIPC;
      7'h6F:   return K_JAL;
      7'h67:   return K_JALR;
      7'h63:   return K_BRANCH;
      7'h0F:   return K_FENCE;
      7'h73:   return K_SYSTEM;
      default: return K_ILLEGAL;
    endcase
  endfunction

  function automatic logic [4:0] imm_of(input kind_e k);
    case (k)
      K_LOAD, K_OPIMM, K_JALR, K_FENCE, K_SYSTEM: return 5'b10000;
      K_STORE:         return 5'b01000;
      K_BRANCH:        return 5'b00100;
      K_LUI, K_AUIPC:  return 5'b00010;
      K_JAL:           return 5'b00001;
      default:         return 5'b00000;
    endcase
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.mem_req = 1'b0; e.mem_addr_sel = 1'b0; e.mem_write = 1'b0;
    e.ir_write = 1'b0; e.pc_write = 1'b0; e.pc_src = 2'd0;
    e.reg_write = 1'b0; e.result_sel = 2'd0; e.retired = 1'b0;
    e.imm_fmt = 5'b0; e.chk_status = 1'b1; e.halt = 1'b0; e.cause = 2'd0;
    e.chk_alu = 1'b0; e.alu_a = 2'd0; e.alu_b = 2'd0; e.alu_op = 2'd0;
    return e;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    compare({tag, " MemReq"},      32'(MemReq),      32'(e.mem_req));
    compare({tag, " MemWrite"},    32'(MemWrite),    32'(e.mem_write));
    compare({tag, " IRWrite"},     32'(IRWrite),     32'(e.ir_write));
    compare({tag, " PCWrite"},     32'(PCWrite),     32'(e.pc_write));
    compare({tag, " RegWrite"},    32'(RegWrite),    32'(e.reg_write));
    compare({tag, " InstRetired"}, 32'(InstRetired), 32'(e.retired));
    compare({tag, " ImmFmt"},      32'(ImmFmt),      32'(e.imm_fmt));
    if (e.mem_req)   compare({tag, " MemAddrSel"}, 32'(MemAddrSel), 32'(e.mem_addr_sel));
    if (e.pc_write)  compare({tag, " PCSrc"},      32'(PCSrc),      32'(e.pc_src));
    if (e.reg_write) compare({tag, " ResultSel"},  32'(ResultSel),  32'(e.result_sel));
    if (e.chk_status) begin
      compare({tag, " Halt"},  32'(Halt),  32'(e.halt));
      compare({tag, " Cause"}, 32'(Cause), 32'(e.cause));
    end
    if (e.chk_alu) begin
      compare({tag, " ALUSrcA"}, 32'(ALUSrcA), 32'(e.alu_a));
      compare({tag, " ALUSrcB"}, 32'(ALUSrcB), 32'(e.alu_b));
      compare({tag, " ALUOp"},   32'(ALUOp),   32'(e.alu_op));
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then sample
  // the outputs well before the next rising edge.
  task automatic stepCycle(input logic [31:0] ins, input logic ready, input logic taken,
                           input logic rst, input exp_t e, input string tag);
    @(negedge Clk);
    Ins = ins; MemReady = ready; BranchTaken = taken; Rst = rst;
    #1;
    checkOutput(tag, e);
  endtask

  task automatic applyReset();
    exp_t e;
    e = idle_exp();
    e.chk_status = 1'b0;
    stepCycle(Ins, 1'b1, 1'b1, 1'b1, e, "reset entry");
    e.chk_status = 1'b1;
    stepCycle(Ins, 1'b1, 1'b1, 1'b1, e, "reset hold");
  endtask

  task automatic trapCheck(input logic [31:0] ins, input logic [1:0] cause, input string tag);
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      e = idle_exp();
      e.halt = 1'b1;
      e.cause = cause;
      stepCycle(ins, 1'b1, 1'b1, 1'b0, e, tag);
    end
  endtask

  // One memory access of `waits` not-ready cycles; at TIMEOUT waits it traps.
  task automatic memPhase(input logic [31:0] ins, input logic taken, input int waits,
                          input logic in_mem, input logic store, input logic [4:0] imm,
                          input string tag, output logic trapped);
    exp_t e;
    logic ready;
    int   last;
    trapped = (waits >= TIMEOUT);
    last = trapped ? TIMEOUT - 1 : waits;
    for (int c = 0; c <= last; c++) begin
      ready = !trapped && (c == waits);
      e = idle_exp();
      e.mem_req = 1'b1;
      e.mem_addr_sel = in_mem;
      e.mem_write = in_mem & store;
      if (in_mem) begin
        e.imm_fmt = imm;
        e.retired = ready & store;
      end else begin
        e.ir_write = ready;
        e.pc_write = ready;
        e.pc_src = 2'd0;
      end
      stepCycle(ins, ready, taken, 1'b0, e, tag);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input int fetch_wait, input int mem_wait,
                               input logic taken, input string name);
    kind_e      k;
    exp_t       e;
    logic       trapped;
    logic [4:0] imm;
    k = kind_of(ins[6:0]);
    imm = imm_of(k);
    memPhase(ins, taken, fetch_wait, 1'b0, 1'b0, imm, {name, " fetch"}, trapped);
    if (trapped) begin
      trapCheck(ins, 2'd3, {name, " fetch timeout"});
      applyReset();
      return;
    end
    e = idle_exp();
    e.imm_fmt = imm;
    stepCycle(ins, 1'($urandom_range(0, 1)), taken, 1'b0, e, {name, " decode"});
    if (k == K_SYSTEM || k == K_ILLEGAL) begin
      trapCheck(ins, (k == K_SYSTEM) ? 2'd2 : 2'd1, {name, " trap"});
      applyReset();
      return;
    end
    e = idle_exp();
    e.imm_fmt = imm;
    case (k)
      K_BRANCH: begin e.pc_write = taken; e.pc_src = 2'd1; e.retired = 1'b1; end
      K_FENCE:  e.retired = 1'b1;
      K_JAL:    begin e.pc_write = 1'b1; e.pc_src = 2'd1; end
      K_JALR:   begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
      K_LOAD, K_STORE: begin
        e.chk_alu = 1'b1; e.alu_a = 2'd0; e.alu_b = 2'd1; e.alu_op = 2'd0;
      end
      default: ;
    endcase
    stepCycle(ins, 1'($urandom_range(0, 1)), taken, 1'b0, e, {name, " exec"});
    if (k == K_BRANCH || k == K_FENCE) return;
    if (k == K_LOAD || k == K_STORE) begin
      memPhase(ins, taken, mem_wait, 1'b1, k == K_STORE, imm, {name, " mem"}, trapped);
      if (trapped) begin
        trapCheck(ins, 2'd3, {name, " mem timeout"});
        applyReset();
        return;
      end
      if (k == K_STORE) return;
    end
    e = idle_exp();
    e.imm_fmt = imm;
    e.reg_write = 1'b1;
    e.retired = 1'b1;
    e.result_sel = (k == K_LOAD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
    stepCycle(ins, 1'($urandom_range(0, 1)), taken, 1'b0, e, {name, " wb"});
  endtask

  logic [6:0]  opc_tab [12] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17,
                                7'h6F, 7'h67, 7'h63, 7'h0F, 7'h73, 7'h7F};

  initial begin
    exp_t        e;
    logic [31:0] r;
    int          fw;
    Rst = 1'b1; Ins = 32'h0; MemReady = 1'b0; BranchTaken = 1'b0;
    applyReset();

    applyStimulus(32'h00500093, 0, 0, 1'b0, "addi");
    applyStimulus(32'h00000463, 0, 0, 1'b1, "beq taken");
    applyStimulus(32'h00000463, 0, 0, 1'b0, "beq not taken");
    applyStimulus(32'h0000A103, 0, 3, 1'b0, "lw late");
    applyStimulus(32'h00112023, 1, 1, 1'b0, "sw");
    applyStimulus(32'h008000EF, 0, 0, 1'b0, "jal");
    applyStimulus(32'h000080E7, 2, 0, 1'b0, "jalr");
    applyStimulus(32'h123452B7, 0, 0, 1'b0, "lui");
    applyStimulus(32'h00000317, 0, 0, 1'b0, "auipc");
    applyStimulus(32'h002081B3, 0, 0, 1'b0, "add");
    applyStimulus(32'h0000000F, 0, 0, 1'b0, "fence");
    applyStimulus(32'h00500093, TIMEOUT - 1, 0, 1'b0, "addi ready at limit");
    applyStimulus(32'h0000A103, 0, TIMEOUT - 1, 1'b0, "lw ready at limit");
    applyStimulus(32'h00500093, TIMEOUT, 0, 1'b0, "fetch timeout");
    applyStimulus(32'h0000007F, 0, 0, 1'b0, "illegal");
    applyStimulus(32'h00000073, 0, 0, 1'b0, "ecall");
    applyStimulus(32'h00112023, 0, TIMEOUT + 1, 1'b0, "sw timeout");

    // Reset in the middle of a load's memory access abandons it.
    e = idle_exp(); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    stepCycle(32'h0000A103, 1'b1, 1'b0, 1'b0, e, "rstmem fetch");
    e = idle_exp(); e.imm_fmt = 5'b10000;
    stepCycle(32'h0000A103, 1'b0, 1'b0, 1'b0, e, "rstmem decode");
    stepCycle(32'h0000A103, 1'b0, 1'b0, 1'b0, e, "rstmem exec");
    e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    stepCycle(32'h0000A103, 1'b0, 1'b0, 1'b0, e, "rstmem mem");
    e = idle_exp(); e.imm_fmt = 5'b10000;
    stepCycle(32'h0000A103, 1'b1, 1'b0, 1'b1, e, "rstmem reset");
    applyStimulus(32'h00500093, 0, 0, 1'b0, "after rstmem");

    for (int i = 0; i < 80; i++) begin
      r  = $urandom();
      fw = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, TIMEOUT - 1));
      applyStimulus({r[31:7], opc_tab[$urandom_range(0, 11)]}, fw,
                    int'($urandom_range(0, TIMEOUT + 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
